ads8681_conv_ctrl: RTL
======================

ADS8681_CONV_CTRL -- requirements
Module: ads8681_conv_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 2: SCLK half-period in clk_in cycles; legal range 1..255.
REQ-002 Parameter T_CONV, default 100: conversion wait in clk_in cycles; legal range 2..65535.
REQ-003 Port clk_in  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port start  input  1  one-cycle conversion request.
REQ-006 Port cmd_valid  input  1  register-command offer.
REQ-007 Port cmd_word  input  32  ADC command frame, MSB first.
REQ-008 Port cmd_ready  output  1  command slot free.
REQ-009 Port busy  output  1  frame in progress (any state other than IDLE).
REQ-010 Port data_valid  output  1  one-cycle pulse: new rx_frame/sample available.
REQ-011 Port rx_frame  output  32  last received MISO frame.
REQ-012 Port sample  output  16  rx_frame[31:16].
REQ-013 Port overrun  output  1  sticky: start arrived while busy.
REQ-014 Port adc_cs_n  output  1  ADC CONVST/CS.
REQ-015 Port adc_sclk  output  1  SPI clock.
REQ-016 Port adc_sdi  output  1  MOSI to ADC.
REQ-017 Port adc_sdo  input  1  MISO from ADC; already synchronous to clk_in.

Function
REQ-018 FSM states SHALL be IDLE, CONV, XFER, DONE; transitions only as stated below.
REQ-019 IDLE: adc_cs_n=0, adc_sclk=0, adc_sdi=0; exit to CONV on start=1 or pending command present.
REQ-020 CONV: adc_cs_n=1 (rising edge starts ADC conversion) for exactly T_CONV cycles, then XFER.
REQ-021 XFER: adc_cs_n=0; exactly 32 SCLK periods, each CLK_DIV cycles low then CLK_DIV cycles high; adc_sclk=0 at XFER entry and exit.
REQ-022 adc_sdi SHALL present tx bit 31-n during the whole low and high phase of SCLK period n (n=0..31).
REQ-023 adc_sdo SHALL be sampled in the clk_in cycle where adc_sclk goes 0->1, shifted MSB first into the rx shift register.
REQ-024 DONE: one cycle; rx_frame/sample updated; data_valid=1; pending command cleared; next state IDLE.
REQ-025 Latency: start in IDLE at cycle 0 -> CONV from cycle 1, XFER from cycle T_CONV+1, data_valid at cycle T_CONV+64*CLK_DIV+1, IDLE one cycle later.
REQ-026 Command slot: single 32-bit register; cmd_ready=1 iff state is IDLE and slot empty; accept on cmd_valid&&cmd_ready.
REQ-027 tx frame SHALL be the pending command if the slot is full at CONV entry, else 32'h0000_0000 (NOP).
REQ-028 Command accepted in the same cycle as start in IDLE SHALL be sent in that frame.
REQ-029 Pending command with no start SHALL itself launch a frame (CONV then XFER) one cycle after acceptance.
REQ-030 start while busy=1 SHALL be ignored and set overrun; overrun clears only on reset.
REQ-031 cmd_valid while cmd_ready=0 SHALL have no effect; offerer holds cmd_valid until accepted.
REQ-032 rx_frame/sample SHALL hold between DONE cycles; data_valid SHALL be 0 outside DONE.

Reset
REQ-033 rst=1 SHALL immediately force state IDLE, adc_cs_n=0, adc_sclk=0, adc_sdi=0, busy=0, data_valid=0, overrun=0, rx_frame=0, cmd slot empty, all counters 0.
REQ-034 Reset mid-CONV or mid-XFER SHALL abort the frame with no data_valid and discard the pending command.
REQ-035 First start after rst release SHALL behave per REQ-025.

Verification
REQ-036 CLK_DIV=2, T_CONV=10, ADC model returns 32'hA5C3_0F0F, start at cycle 0 -> cs_n high cycles 1-10, 32 SCLK pulses cycles 11-138, data_valid at 139, sample=16'hA5C3, sdi all 0.
REQ-037 cmd_word=32'hD014_0005 offered alone in IDLE -> accepted one cycle, frame launched, sdi stream equals 0xD0140005 MSB first, cmd_ready=0 until IDLE.
REQ-038 start at cycle 0 plus start at cycle 50 -> second ignored, overrun=1 and stays 1, exactly one data_valid.
REQ-039 start and cmd_valid in same IDLE cycle -> single frame carrying the command, one data_valid, slot empty afterwards.
REQ-040 rst asserted at cycle 60 of a frame -> outputs at reset values same cycle, no data_valid; next start yields normal frame.
REQ-041 Back-to-back start on each IDLE cycle over 8 frames -> 8 data_valid pulses, period T_CONV+64*CLK_DIV+2 cycles, overrun=0.

Source files
------------

// File: rtl/ads8681_conv_ctrl.sv
// ADS8681 conversion/transfer sequencer: CONVST pulse, 32-bit SPI frame
// with optional register command, MISO capture and sample hand-off.
module ads8681_conv_ctrl #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned T_CONV  = 100
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        start,
    input  logic        cmd_valid,
    input  logic [31:0] cmd_word,
    output logic        cmd_ready,
    output logic        busy,
    output logic        data_valid,
    output logic [31:0] rx_frame,
    output logic [15:0] sample,
    output logic        overrun,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        adc_sdi,
    input  logic        adc_sdo
);

    typedef enum logic [1:0] {IDLE, CONV, XFER, DONE} state_t;

    localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [15:0] CONV_LAST = 16'(T_CONV - 1);

    state_t      state_q, state_d;
    logic [15:0] conv_cnt_q, conv_cnt_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic        half_q, half_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] tx_q, tx_d;
    logic [31:0] rx_shift_q, rx_shift_d;
    logic [31:0] rx_frame_q, rx_frame_d;
    logic [31:0] slot_q, slot_d;
    logic        slot_full_q, slot_full_d;
    logic        overrun_q, overrun_d;
    logic        accept_s;

    // State register and datapath flops.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            conv_cnt_q  <= 16'd0;
            div_cnt_q   <= 8'd0;
            half_q      <= 1'b0;
            bit_cnt_q   <= 5'd0;
            tx_q        <= 32'd0;
            rx_shift_q  <= 32'd0;
            rx_frame_q  <= 32'd0;
            slot_q      <= 32'd0;
            slot_full_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            conv_cnt_q  <= conv_cnt_d;
            div_cnt_q   <= div_cnt_d;
            half_q      <= half_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
            rx_shift_q  <= rx_shift_d;
            rx_frame_q  <= rx_frame_d;
            slot_q      <= slot_d;
            slot_full_q <= slot_full_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_d     = state_q;
        conv_cnt_d  = conv_cnt_q;
        div_cnt_d   = div_cnt_q;
        half_d      = half_q;
        bit_cnt_d   = bit_cnt_q;
        tx_d        = tx_q;
        rx_shift_d  = rx_shift_q;
        rx_frame_d  = rx_frame_q;
        slot_d      = slot_q;
        slot_full_d = slot_full_q;
        overrun_d   = overrun_q;
        accept_s    = cmd_valid && (state_q == IDLE) && !slot_full_q;

        if (start && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    slot_d      = cmd_word;
                    slot_full_d = 1'b1;
                end else begin
                    slot_full_d = slot_full_q;
                end
                // A command accepted alongside start rides in this same frame.
                if (start || slot_full_q) begin
                    state_d    = CONV;
                    conv_cnt_d = 16'd0;
                    tx_d       = accept_s ? cmd_word : (slot_full_q ? slot_q : 32'h0000_0000);
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                if (conv_cnt_q == CONV_LAST) begin
                    state_d    = XFER;
                    conv_cnt_d = 16'd0;
                    div_cnt_d  = 8'd0;
                    half_d     = 1'b0;
                    bit_cnt_d  = 5'd0;
                end else begin
                    conv_cnt_d = conv_cnt_q + 16'd1;
                end
            end
            XFER: begin
                // MISO is captured in the first cycle of each high phase.
                if (half_q && (div_cnt_q == 8'd0)) begin
                    rx_shift_d = {rx_shift_q[30:0], adc_sdo};
                end else begin
                    rx_shift_d = rx_shift_q;
                end
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = 8'd0;
                    if (half_q) begin
                        half_d    = 1'b0;
                        tx_d      = {tx_q[30:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd31) begin
                            state_d    = DONE;
                            rx_frame_d = rx_shift_d;
                        end else begin
                            state_d = XFER;
                        end
                    end else begin
                        half_d = 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d     = IDLE;
                slot_full_d = 1'b0;
                slot_d      = 32'd0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready  = (state_q == IDLE) && !slot_full_q;
    assign busy       = (state_q != IDLE);
    assign data_valid = (state_q == DONE);
    assign rx_frame   = rx_frame_q;
    assign sample     = rx_frame_q[31:16];
    assign overrun    = overrun_q;
    assign adc_cs_n   = (state_q == CONV);
    assign adc_sclk   = (state_q == XFER) && half_q;
    assign adc_sdi    = (state_q == XFER) && tx_q[31];

endmodule
